hamming_rx_decoder: RTL and testbench

//  Receive end of the strobed serial Hamming(7,4) link, downstream of the error-injection stage.

---
 rtl/hamming_rx_decoder.sv | 186 ++++++++++++++++++
 tb/tb_hamming_rx_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_rx_decoder.sv
// hamming_rx_decoder
//   Receive side of the strobed serial Hamming(7,4) link. Codeword bits arrive
//   c[0] first while strobe_in=1. The 3-bit syndrome is formed on the received
//   word, any single-bit error is corrected, and the data nibble is presented
//   on a valid/ready output register together with status flags.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   strobe_in      d_in holds a valid codeword bit this cycle
//   d_in           serial codeword bit
//   d_out          corrected data word d[3:0]
//   syndrome       syndrome of the frame on d_out
//   corrected      a data bit was flipped back
//   parity_err     the single error hit a parity bit, data untouched
//   out_valid      word outputs valid, held until out_ready
//   out_ready      consumer accepts on out_valid && out_ready
//   overflow       1-cycle pulse: frame decoded while previous word unaccepted, new frame dropped
//   abort          1-cycle pulse: partial frame discarded after TIMEOUT idle cycles
//
// States
//   IDLE   | waiting for c[0] of a frame
//   SHIFT  | collecting c[1..6]; counting idle gaps for timeout
//   DECODE | one cycle: syndrome, correction, output register update

module hamming_rx_decoder #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_in,
  input  logic       d_in,
  output logic [3:0] d_out,
  output logic [2:0] syndrome,
  output logic       corrected,
  output logic       parity_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       abort
);

  localparam int GW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0]    sr_q, sr_d;

  logic [3:0]    d_out_q, d_out_d;
  logic [2:0]    syndrome_q, syndrome_d;
  logic          corrected_q, corrected_d;
  logic          parity_err_q, parity_err_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic          abort_q, abort_d;

  logic          gap_hit;
  logic [2:0]    syn;
  logic [3:0]    fix_mask;

  // Bits shift in at the MSB, so after seven strobes c[0] sits at sr_q[0].
  assign gap_hit = (state_q == SHIFT) && !strobe_in && (gap_q == GW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sr_q    <= sr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE, DECODE: begin
        if (strobe_in) begin
          sr_d    = {d_in, sr_q[6:1]};
          cnt_d   = 3'd1;
          gap_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (strobe_in) begin
          sr_d  = {d_in, sr_q[6:1]};
          gap_d = '0;
          if (cnt_q == 3'd6) begin
            cnt_d   = '0;
            state_d = DECODE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (gap_hit) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: syndrome, correction and output register
  always_comb begin
    syn[0] = sr_q[4] ^ sr_q[0] ^ sr_q[1] ^ sr_q[3];
    syn[1] = sr_q[5] ^ sr_q[0] ^ sr_q[2] ^ sr_q[3];
    syn[2] = sr_q[6] ^ sr_q[1] ^ sr_q[2] ^ sr_q[3];

    case (syn)
      3'b011:  fix_mask = 4'b0001;
      3'b101:  fix_mask = 4'b0010;
      3'b110:  fix_mask = 4'b0100;
      3'b111:  fix_mask = 4'b1000;
      default: fix_mask = 4'b0000;
    endcase

    d_out_d      = d_out_q;
    syndrome_d   = syndrome_q;
    corrected_d  = corrected_q;
    parity_err_d = parity_err_q;
    out_valid_d  = out_valid_q;
    overflow_d   = 1'b0;
    abort_d      = gap_hit;

    if (state_q == DECODE) begin
      // Accepting the old word and loading the new one share an edge: no bubble.
      if (!out_valid_q || out_ready) begin
        d_out_d      = sr_q[3:0] ^ fix_mask;
        syndrome_d   = syn;
        corrected_d  = (fix_mask != 4'b0000);
        parity_err_d = (syn == 3'b001) || (syn == 3'b010) || (syn == 3'b100);
        out_valid_d  = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q      <= '0;
      syndrome_q   <= '0;
      corrected_q  <= 1'b0;
      parity_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      d_out_q      <= d_out_d;
      syndrome_q   <= syndrome_d;
      corrected_q  <= corrected_d;
      parity_err_q <= parity_err_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      abort_q      <= abort_d;
    end
  end

  assign d_out      = d_out_q;
  assign syndrome   = syndrome_q;
  assign corrected  = corrected_q;
  assign parity_err = parity_err_q;
  assign out_valid  = out_valid_q;
  assign overflow   = overflow_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_hamming_rx_decoder.sv
module tb_hamming_rx_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe_in;
  logic       d_in;
  logic [3:0] d_out;
  logic [2:0] syndrome;
  logic       corrected;
  logic       parity_err;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       abort;

  hamming_rx_decoder #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .strobe_in(strobe_in), .d_in(d_in),
    .d_out(d_out), .syndrome(syndrome), .corrected(corrected),
    .parity_err(parity_err), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] cw;    // {c6..c0}
    logic [3:0] d;
    logic [2:0] s;
    logic       corr;
    logic       perr;
  } vec_t;

  vec_t        vecs[$];
  logic [8:0]  sb[$];   // expected {d, s, corr, perr}
  int          n_checks = 0;
  int          n_pass   = 0;
  int          abort_cnt = 0;
  int          ovf_cnt   = 0;
  int          word_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p0, p1, p2;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    return {p2, p1, p0, d};
  endfunction

  // Syndrome produced by a single flip at codeword position k
  function automatic logic [2:0] pos_syn(input int k);
    case (k)
      0: return 3'b011;
      1: return 3'b101;
      2: return 3'b110;
      3: return 3'b111;
      4: return 3'b001;
      5: return 3'b010;
      6: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic send_bits(input logic [6:0] cw, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      strobe_in = 1'b1;
      d_in      = cw[i];
      @(posedge clk); #1;
    end
    strobe_in = 1'b0;
    d_in      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_drained"}, sb.size(), 0);
  endtask

  function automatic logic [8:0] pack(input logic [3:0] d, input logic [2:0] s,
                                      input logic c, input logic p);
    return {d, s, c, p};
  endfunction

  // Monitor: scoreboard pops on handshake, pulse counting, hold-stability check
  logic       hold_prev = 1'b0;
  logic [8:0] prev_word;

  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (abort)    abort_cnt++;
      if (overflow) ovf_cnt++;
      if (hold_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_word", {d_out, syndrome, corrected, parity_err}, prev_word);
      end
      if (out_valid && out_ready) begin
        word_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_word", {d_out, syndrome, corrected, parity_err}, 9'h1ff);
        end else begin
          exp = sb.pop_front();
          check("word", {d_out, syndrome, corrected, parity_err}, exp);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_word = {d_out, syndrome, corrected, parity_err};
    end
  end

  initial begin
    int a0, o0, w0;
    logic [6:0] cw;

    // Spec vectors, then every data word with no error and each single-bit error
    vecs.push_back('{7'b0011011, 4'b1011, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{7'b0011001, 4'b1011, 3'b101, 1'b1, 1'b0});
    vecs.push_back('{7'b0011010, 4'b1011, 3'b011, 1'b1, 1'b0});
    vecs.push_back('{7'b0001011, 4'b1011, 3'b001, 1'b0, 1'b1});
    for (int d = 0; d < 16; d++) begin
      for (int e = -1; e < 7; e++) begin
        cw = encode(4'(d));
        if (e >= 0) cw[e] = ~cw[e];
        vecs.push_back('{cw, 4'(d), pos_syn(e), (e >= 0 && e < 4), (e >= 4)});
      end
    end

    rst = 1'b1; strobe_in = 1'b0; d_in = 1'b0; out_ready = 1'b0;
    idle(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_word", {d_out, syndrome, corrected, parity_err}, 9'h0);
    check("rst_pulses", {overflow, abort}, 2'b00);
    rst = 1'b0;
    idle(2);
    check("idle_valid", out_valid, 1'b0);

    // Table-driven vectors
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      sb.push_back(pack(vecs[i].d, vecs[i].s, vecs[i].corr, vecs[i].perr));
      send_bits(vecs[i].cw, 7);
      check("pre_latency", out_valid, 1'b0);
      idle(1);
      check("latency_valid", out_valid, 1'b1);
    end
    drain("table");

    // 3-cycle gap after bit 4
    a0 = abort_cnt;
    sb.push_back(pack(4'b1011, 3'b000, 1'b0, 1'b0));
    send_bits(7'b0011011, 4);
    idle(3);
    send_bits(7'b0011011 >> 4, 3);
    drain("gap3");

    // Gap of TIMEOUT-1: still no abort
    sb.push_back(pack(4'b1011, 3'b000, 1'b0, 1'b0));
    send_bits(7'b0011011, 4);
    idle(15);
    send_bits(7'b0011011 >> 4, 3);
    drain("gap15");
    check("gap15_no_abort", abort_cnt, a0);

    // Gap of TIMEOUT: abort, no word
    w0 = word_cnt;
    send_bits(7'b0011011, 4);
    idle(15);
    check("abort_early", abort, 1'b0);
    idle(1);
    check("abort_pulse", abort, 1'b1);
    idle(1);
    check("abort_one_cycle", abort, 1'b0);
    idle(5);
    check("abort_count", abort_cnt, a0 + 1);
    check("abort_no_word", word_cnt, w0);
    check("abort_no_valid", out_valid, 1'b0);
    sb.push_back(pack(4'b0110, 3'b000, 1'b0, 1'b0));
    send_bits(encode(4'b0110), 7);
    drain("after_abort");

    // Back-to-back with out_ready=0: second frame overflows
    idle(2);
    out_ready = 1'b0;
    o0 = ovf_cnt;
    send_bits(7'b0011011, 7);
    send_bits(encode(4'b0101), 7);
    idle(1);
    check("ovf_pulse", overflow, 1'b1);
    check("ovf_keep_word", d_out, 4'b1011);
    check("ovf_valid", out_valid, 1'b1);
    idle(1);
    check("ovf_one_cycle", overflow, 1'b0);
    check("ovf_count", ovf_cnt, o0 + 1);
    sb.push_back(pack(4'b1011, 3'b000, 1'b0, 1'b0));
    out_ready = 1'b1;
    drain("ovf");
    idle(1);
    check("ovf_valid_drop", out_valid, 1'b0);

    // Back-to-back, ready rises during second frame's decode: no bubble
    out_ready = 1'b0;
    sb.push_back(pack(4'b1011, 3'b000, 1'b0, 1'b0));
    sb.push_back(pack(4'b0101, 3'b000, 1'b0, 1'b0));
    send_bits(7'b0011011, 7);
    send_bits(encode(4'b0101), 7);
    out_ready = 1'b1;
    idle(1);
    check("nobubble_valid", out_valid, 1'b1);
    check("nobubble_word", d_out, 4'b0101);
    check("nobubble_no_ovf", overflow, 1'b0);
    drain("nobubble");

    // Reset mid-frame with a held word
    idle(2);
    out_ready = 1'b0;
    a0 = abort_cnt; o0 = ovf_cnt;
    send_bits(7'b0011011, 7);
    idle(1);
    check("pre_rst_valid", out_valid, 1'b1);
    send_bits(encode(4'b0101), 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_word", d_out, 4'b0000);
    out_ready = 1'b1;
    sb.push_back(pack(4'b0110, 3'b000, 1'b0, 1'b0));
    send_bits(encode(4'b0110), 7);
    drain("after_rst");
    idle(20);
    check("rst_no_pulses", abort_cnt + ovf_cnt, a0 + o0);
    check("final_queue", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
